// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel registered mux with fixed-select and round-robin arbitration
module mux_rr_n #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_src,
  input  logic            out_ready
);
  logic [SELW-1:0] rr_ptr, g_idx, rr_next;
  logic [2*N-1:0]  rot;
  logic [W-1:0]    g_data;
  logic            g_hit, space, xfer;
  assign space   = !out_valid || out_ready;
  assign xfer    = g_hit && space;
  assign rr_next = (g_idx == SELW'(N-1)) ? '0 : g_idx + 1'b1;
  assign in_ready = (xfer && !reset) ? N'(1) << g_idx : '0;
  // grant: sel in fixed mode; first valid channel at or after rr_ptr (wrapping) in round-robin mode
  always_comb begin
    g_hit = 1'b0;
    g_idx = '0;
    rot   = {in_valid, in_valid} >> rr_ptr;
    for (int i = 0; i < N; i++)
      if (!mode && sel == SELW'(i) && in_valid[i]) begin
        g_hit = 1'b1;
        g_idx = SELW'(i);
      end
    for (int k = N - 1; k >= 0; k--)
      if (mode && rot[k]) begin
        g_hit = 1'b1;
        g_idx = SELW'((int'(rr_ptr) + k >= N) ? int'(rr_ptr) + k - N : int'(rr_ptr) + k);
      end
  end
  // only the granted channel's slice is routed, so other channels' data cannot leak into the register
  always_comb begin
    g_data = '0;
    for (int i = 0; i < N; i++)
      if (g_idx == SELW'(i)) g_data = in_data[i*W +: W];
  end
  // one-entry output register; reload on transfer, empty on drain, round-robin pointer advances past winner
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_src   <= g_idx;
      if (mode) rr_ptr <= rr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: scoreboard bench for the registered round-robin mux
module tb_mux_rr_n;
  localparam int W = 32, N = 4, SELW = 2;
  logic clk = 1'b0, reset = 1'b1, mode = 1'b1, out_ready = 1'b1;
  logic [SELW-1:0] sel = '0;
  logic [N-1:0] in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_ready;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [SELW-1:0] out_src;
  int checks = 0, errors = 0;
  logic [SELW+W-1:0] q[$];
  logic [SELW-1:0] m_rr = '0;

  always #5 clk = ~clk;

  mux_rr_n #(.W(W), .N(N), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_grant(input logic md, input logic [SELW-1:0] s,
                                               input logic [N-1:0] v, input logic [SELW-1:0] rr);
    model_grant = '0;
    if (!md) begin
      if (int'(s) < N && v[s]) model_grant[s] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (int'(rr) + k) % N;
        if (v[c]) begin
          model_grant[c] = 1'b1;
          return model_grant;
        end
      end
    end
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [SELW+W-1:0] e;
    if (reset) begin
      check("reset_in_ready", in_ready, 0);
      q.delete();
      m_rr = '0;
    end else begin
      check("out_valid", out_valid, q.size() != 0);
      eg = (q.size() == 0 || out_ready) ? model_grant(mode, sel, in_valid, m_rr) : '0;
      check("in_ready", in_ready, eg);
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front();
        check("out_data", out_data, e[W-1:0]);
        check("out_src", out_src, e[SELW+W-1:W]);
      end
      for (int i = 0; i < N; i++)
        if (eg[i]) begin
          q.push_back({SELW'(i), in_data[i*W +: W]});
          if (mode) m_rr = SELW'((i + 1) % N);
        end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + i;
    in_valid = '1;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    step();
    reset = 1'b0;
    step(9);
    in_valid = 4'b0100;
    step();
    in_valid = 4'b1010;
    step(3);
    in_data[2*W +: W] = 32'hDEADBEEF;
    in_valid = 4'b0100;
    step();
    out_ready = 1'b0;
    in_valid = 4'b1100;
    repeat (3) begin
      step();
      check("bp_data", out_data, 32'hDEADBEEF);
      check("bp_src", out_src, 2);
    end
    out_ready = 1'b1;
    step();
    in_valid = '0;
    mode = 1'b0;
    sel = 2'd2;
    in_valid = 4'b1111;
    step(4);
    check("fixed_src", out_src, 2);
    sel = 2'd3;
    in_valid = 4'b0111;
    step(2);
    check("fixed_idle", out_valid, 0);
    mode = 1'b1;
    in_valid = 4'b0001;
    step();
    in_valid = '0;
    out_ready = 1'b0;
    step();
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    in_valid = '1;
    step();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    step(2);
    repeat (300) begin
      mode = $urandom_range(0, 3) != 0;
      sel = SELW'($urandom);
      in_valid = N'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = in_valid[i] ? $urandom : {W{1'bx}};
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
